// File: rtl/microprogram_sequencer.sv
// Microprogram sequencer: decodes the microword branch field into the next-address
// mux select, supplies candidate addresses and owns CAR plus a one-deep return register.
module microprogram_sequencer #(
   parameter int unsigned    AW         = 16,
   parameter logic [AW-1:0]  RESET_ADDR = 16'h0000,
   parameter logic [AW-1:0]  MAP_BASE   = 16'h0040,
   parameter int unsigned    MAP_SHIFT  = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic          stall,
   input  logic [7:0]    opcode,
   input  logic [2:0]    br_type,
   input  logic [AW-1:0] jump_field,
   input  logic          flag_z,
   input  logic [AW-1:0] car_next,
   output logic [1:0]    mux_sel,
   output logic [AW-1:0] inc_addr,
   output logic [AW-1:0] jump_addr,
   output logic [AW-1:0] map_addr,
   output logic [AW-1:0] car,
   output logic          busy,
   output logic          done
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   typedef enum logic [2:0] {
      BR_NEXT = 3'b000,
      BR_JUMP = 3'b001,
      BR_JZ   = 3'b010,
      BR_JNZ  = 3'b011,
      BR_MAP  = 3'b100,
      BR_CALL = 3'b101,
      BR_RET  = 3'b110,
      BR_END  = 3'b111
   } br_t;

   state_t        state, state_nx;
   logic [AW-1:0] ret_reg;
   logic [AW-1:0] op_ext;
   logic          car_load;
   logic          ret_load;
   br_t           br;

   assign br       = br_t'(br_type);
   assign op_ext   = AW'(opcode);
   assign inc_addr = car + 1'b1;
   assign map_addr = MAP_BASE + (op_ext << MAP_SHIFT);
   assign jump_addr = (br == BR_RET) ? ret_reg : jump_field;
   assign busy     = (state == RUN) || (state == DONE);
   assign done     = (state == DONE);

   always_comb begin
      state_nx = state;
      mux_sel  = 2'd0;
      car_load = 1'b0;
      ret_load = 1'b0;
      unique case (state)
         IDLE: begin
            if (start) state_nx = RUN;
         end
         RUN: begin
            unique case (br)
               BR_NEXT: mux_sel = 2'd0;
               BR_JUMP: mux_sel = 2'd1;
               BR_JZ:   mux_sel = flag_z ? 2'd1 : 2'd0;
               BR_JNZ:  mux_sel = flag_z ? 2'd0 : 2'd1;
               BR_MAP:  mux_sel = 2'd2;
               BR_CALL: mux_sel = 2'd1;
               BR_RET:  mux_sel = 2'd1;
               BR_END:  mux_sel = 2'd0;
               default: mux_sel = 2'd0;
            endcase
            // Stall freezes everything, including the END-to-DONE transition.
            if (!stall) begin
               if (br == BR_END) begin
                  state_nx = DONE;
               end else begin
                  car_load = 1'b1;
                  ret_load = (br == BR_CALL);
               end
            end
         end
         DONE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         car     <= '0;
         ret_reg <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && start) car <= RESET_ADDR;
         else if (car_load)          car <= car_next;
         if (ret_load) ret_reg <= inc_addr;
      end
   end

endmodule

// File: tb/tb_microprogram_sequencer.sv
// Directed self-checking bench for microprogram_sequencer; the bench supplies the
// external next-address mux so CAR follows the selected candidate.
module tb_microprogram_sequencer;

   localparam int unsigned AW = 16;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic          stall;
   logic [7:0]    opcode;
   logic [2:0]    br_type;
   logic [AW-1:0] jump_field;
   logic          flag_z;
   logic [AW-1:0] car_next;
   logic [1:0]    mux_sel;
   logic [AW-1:0] inc_addr;
   logic [AW-1:0] jump_addr;
   logic [AW-1:0] map_addr;
   logic [AW-1:0] car;
   logic          busy;
   logic          done;

   int n_cmp = 0;
   int n_err = 0;

   microprogram_sequencer #(
      .AW(AW),
      .RESET_ADDR(16'h0000),
      .MAP_BASE(16'h0040),
      .MAP_SHIFT(2)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .start(start),
      .stall(stall),
      .opcode(opcode),
      .br_type(br_type),
      .jump_field(jump_field),
      .flag_z(flag_z),
      .car_next(car_next),
      .mux_sel(mux_sel),
      .inc_addr(inc_addr),
      .jump_addr(jump_addr),
      .map_addr(map_addr),
      .car(car),
      .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   // External next-address mux of the control unit
   always_comb begin
      case (mux_sel)
         2'd0:    car_next = inc_addr;
         2'd2:    car_next = map_addr;
         default: car_next = jump_addr;
      endcase
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; start = 1'b0; stall = 1'b0; opcode = 8'h00;
      br_type = 3'b000; jump_field = '0; flag_z = 1'b0;
      #3;
      check("rst_car", car, 32'h0);
      check("rst_busy", busy, 32'h0);
      check("rst_done", done, 32'h0);
      check("rst_sel", mux_sel, 32'h0);
      step(); step();
      rst_n = 1'b1;

      // IDLE ignores branch field; start beats stall
      br_type = 3'b001; jump_field = 16'h0123;
      #1 check("idle_sel", mux_sel, 32'h0);
      step();
      check("idle_hold", car, 32'h0);
      check("idle_busy", busy, 32'h0);
      start = 1'b1; stall = 1'b1;
      step();
      start = 1'b0; stall = 1'b0;
      check("start_car", car, 32'h0);
      check("start_busy", busy, 32'h1);

      br_type = 3'b000;
      #1 check("next_sel", mux_sel, 32'h0);
      step(); check("next1", car, 32'h1);
      step(); check("next2", car, 32'h2);
      step(); check("next3", car, 32'h3);
      check("run_busy", busy, 32'h1);

      br_type = 3'b001; jump_field = 16'h0123;
      #1 check("jump_sel", mux_sel, 32'h1);
      step(); check("jump_car", car, 32'h0123);

      br_type = 3'b010; jump_field = 16'h0300; flag_z = 1'b0;
      #1 check("jz0_sel", mux_sel, 32'h0);
      step(); check("jz0_car", car, 32'h0124);
      flag_z = 1'b1;
      #1 check("jz1_sel", mux_sel, 32'h1);
      step(); check("jz1_car", car, 32'h0300);
      br_type = 3'b011;
      #1 check("jnz1_sel", mux_sel, 32'h0);
      step(); check("jnz1_car", car, 32'h0301);
      flag_z = 1'b0; jump_field = 16'h0010;
      #1 check("jnz0_sel", mux_sel, 32'h1);
      step(); check("jnz0_car", car, 32'h0010);

      br_type = 3'b101; jump_field = 16'h0200;
      #1 check("call_sel", mux_sel, 32'h1);
      step(); check("call_car", car, 32'h0200);
      br_type = 3'b000;
      step(); check("sub_car", car, 32'h0201);
      br_type = 3'b110; jump_field = 16'h0777;
      #1 check("ret_addr", jump_addr, 32'h0011);
      check("ret_sel", mux_sel, 32'h1);
      step(); check("ret_car", car, 32'h0011);

      br_type = 3'b100; opcode = 8'h05;
      #1 check("map_addr", map_addr, 32'h0054);
      check("map_sel", mux_sel, 32'h2);
      step(); check("map_car", car, 32'h0054);
      opcode = 8'hFF;
      #1 check("map_ff", map_addr, 32'h043C);

      br_type = 3'b000; stall = 1'b1;
      step(); check("stall1", car, 32'h0054);
      step(); check("stall2", car, 32'h0054);
      step(); check("stall3", car, 32'h0054);
      check("stall_inc", inc_addr, 32'h0055);
      stall = 1'b0;
      step(); check("unstall", car, 32'h0055);

      br_type = 3'b001; jump_field = 16'hFFFF;
      step(); check("to_ffff", car, 32'hFFFF);
      check("wrap_inc", inc_addr, 32'h0);
      br_type = 3'b000;
      step(); check("wrap_car", car, 32'h0);

      br_type = 3'b111; stall = 1'b1;
      #1 check("end_sel", mux_sel, 32'h0);
      step(); check("end_st_done", done, 32'h0);
      check("end_st_car", car, 32'h0);
      step(); check("end_st_done2", done, 32'h0);
      stall = 1'b0; start = 1'b1;
      step(); check("done_pulse", done, 32'h1);
      check("done_busy", busy, 32'h1);
      check("done_car", car, 32'h0);
      step(); start = 1'b0;
      check("done_clr", done, 32'h0);
      check("idle_busy2", busy, 32'h0);
      step(); check("idle_busy3", busy, 32'h0);

      start = 1'b1;
      step(); start = 1'b0;
      br_type = 3'b001; jump_field = 16'h0ABC;
      step(); check("pre_rst_car", car, 32'h0ABC);
      #2 rst_n = 1'b0;
      #1 check("arst_car", car, 32'h0);
      check("arst_busy", busy, 32'h0);
      check("arst_sel", mux_sel, 32'h0);
      @(negedge clk); rst_n = 1'b1;

      start = 1'b1; br_type = 3'b000;
      step(); start = 1'b0;
      step(); check("post_rst_car", car, 32'h1);
      br_type = 3'b110; jump_field = 16'h0555;
      #1 check("ret_nocall", jump_addr, 32'h0);
      step(); check("ret_nocall_car", car, 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
